// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide, one bit per cycle, valid/ready on both sides.
// Optional MD_FLUSH_EN adds a flush input that aborts any operation back to IDLE.
module mul_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
`ifdef MD_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam int HW = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic              word_reg;
  logic              q_neg_reg;
  logic              r_neg_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opb_reg;
  logic [XLEN-1:0]   result_reg;

  logic flush_w;
`ifdef MD_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{(XLEN-HW){x[HW-1]}}, x[HW-1:0]};
  endfunction

  // Operand decode: illegal word MULH* variants collapse onto MULW.
  logic [2:0]      op_eff;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_raw, spec_res;
  logic            div_zero, div_ovf, special, accept;

  always_comb begin
    op_eff   = (is_word && !op[2]) ? OP_MUL : op;
    a_signed = (op_eff == OP_MULH) || (op_eff == OP_MULHSU) ||
               (op_eff == OP_DIV)  || (op_eff == OP_REM);
    b_signed = (op_eff == OP_MULH) || (op_eff == OP_DIV) || (op_eff == OP_REM);
    if (is_word) begin
      a_ext = a_signed ? sext_w(a) : {{(XLEN-HW){1'b0}}, a[HW-1:0]};
      b_ext = b_signed ? sext_w(b) : {{(XLEN-HW){1'b0}}, b[HW-1:0]};
    end else begin
      a_ext = a;
      b_ext = b;
    end
    a_neg = a_signed && a_ext[XLEN-1];
    b_neg = b_signed && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    min_val  = is_word ? {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}}
                       : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = op_eff[2] && (b_ext == '0);
    div_ovf  = op_eff[2] && !op_eff[0] && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || div_ovf;

    if (div_zero) spec_raw = op_eff[1] ? a_ext : '1;
    else          spec_raw = op_eff[1] ? '0 : a_ext;
    spec_res = is_word ? sext_w(spec_raw) : spec_raw;

    accept = in_valid && (state_reg == S_IDLE) && !flush_w;
  end

  // One iteration: shift-add multiply or restoring divide on the shared accumulator.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    div_sh   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_reg};
    if (op_reg[2]) begin
      if (!div_diff[XLEN]) acc_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
      else                 acc_step = {div_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_reg[XLEN-1:1]};
    end
  end

  logic last_iter;
  assign last_iter = (cnt_reg == (word_reg ? CW'(HW-1) : CW'(XLEN-1)));

  // Sign fix-up and result selection; word products sit shifted up by HW bits.
  logic [XLEN-1:0] acc_hi, acc_lo, quo, rem, mul_lo, mul_hi, fix_raw, fix_res;

  always_comb begin
    acc_hi  = acc_reg[2*XLEN-1:XLEN];
    acc_lo  = acc_reg[XLEN-1:0];
    mul_hi  = q_neg_reg ? (~acc_hi + XLEN'(acc_lo == '0)) : acc_hi;
    mul_lo  = word_reg ? acc_reg[XLEN+HW-1:HW] : acc_lo;
    quo     = q_neg_reg ? -acc_lo : acc_lo;
    rem     = r_neg_reg ? -acc_hi : acc_hi;
    if (op_reg[2])             fix_raw = op_reg[1] ? rem : quo;
    else if (op_reg[1:0] == 2'b00) fix_raw = mul_lo;
    else                       fix_raw = mul_hi;
    fix_res = word_reg ? sext_w(fix_raw) : fix_raw;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = special ? S_DONE : S_CALC;
      S_CALC:  if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush_w) state_next = S_IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_reg     <= '0;
      word_reg   <= 1'b0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (accept) begin
          op_reg    <= op_eff;
          word_reg  <= is_word;
          q_neg_reg <= a_neg ^ b_neg;
          r_neg_reg <= a_neg;
          cnt_reg   <= '0;
          opb_reg   <= b_mag;
          // Word dividends are left-aligned so the MSB always enters at bit XLEN-1.
          acc_reg   <= {{XLEN{1'b0}},
                        (op_eff[2] && is_word) ? {a_mag[HW-1:0], {(XLEN-HW){1'b0}}} : a_mag};
          if (special) result_reg <= spec_res;
        end
        S_CALC: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_FIX: if (!flush_w) result_reg <= fix_res;
        default: ;
      endcase
    end
  end

  assign result = result_reg;

endmodule
